c7bbiu_rd_sched: RTL and testbench

- Read-channel scheduler for the BIU. Shares one AXI read address/data channel between IFU fetch and LSU load.
- Issues a registered AR with a fixed per-requester ID and tracks one outstanding read per requester.
- Steers R beats back to their owner by RID and silently drains reads the IFU has cancelled.
- Sits between the IFU/LSU request ports and the external AXI master port.

---
 rtl/c7bbiu_pkg.sv | 16 +
 rtl/c7bbiu_rd_sched_if.sv | 60 ++++++
 rtl/c7bbiu_rd_track.sv | 63 ++++++
 rtl/c7bbiu_rd_sched.sv | 134 +++++++++++++
 tb/tb_c7bbiu_rd_sched.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/c7bbiu_pkg.sv
// BIU read scheduler shared types.
// Tracker states and fixed AXI encodings.
package c7bbiu_pkg;

  typedef enum logic [1:0] {
    TRK_IDLE,
    TRK_ADDR,
    TRK_DATA,
    TRK_DROP
  } trk_state_e;

  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/c7bbiu_rd_sched_if.sv
// AXI read address/data channel between BIU and fabric.
// master = BIU side, slave = fabric side.
interface c7bbiu_rd_sched_if;

  logic        ext_biu_ar_ready;
  logic        biu_ext_ar_valid;
  logic [3:0]  biu_ext_ar_id;
  logic [31:0] biu_ext_ar_addr;
  logic [7:0]  biu_ext_ar_len;
  logic [2:0]  biu_ext_ar_size;
  logic [1:0]  biu_ext_ar_burst;
  logic        biu_ext_ar_lock;
  logic [3:0]  biu_ext_ar_cache;
  logic [2:0]  biu_ext_ar_prot;
  logic        biu_ext_r_ready;
  logic        ext_biu_r_valid;
  logic [3:0]  ext_biu_r_id;
  logic [31:0] ext_biu_r_data;
  logic        ext_biu_r_last;
  logic [1:0]  ext_biu_r_resp;

  modport master (
    input  ext_biu_ar_ready,
    output biu_ext_ar_valid,
    output biu_ext_ar_id,
    output biu_ext_ar_addr,
    output biu_ext_ar_len,
    output biu_ext_ar_size,
    output biu_ext_ar_burst,
    output biu_ext_ar_lock,
    output biu_ext_ar_cache,
    output biu_ext_ar_prot,
    output biu_ext_r_ready,
    input  ext_biu_r_valid,
    input  ext_biu_r_id,
    input  ext_biu_r_data,
    input  ext_biu_r_last,
    input  ext_biu_r_resp
  );

  modport slave (
    output ext_biu_ar_ready,
    input  biu_ext_ar_valid,
    input  biu_ext_ar_id,
    input  biu_ext_ar_addr,
    input  biu_ext_ar_len,
    input  biu_ext_ar_size,
    input  biu_ext_ar_burst,
    input  biu_ext_ar_lock,
    input  biu_ext_ar_cache,
    input  biu_ext_ar_prot,
    input  biu_ext_r_ready,
    output ext_biu_r_valid,
    output ext_biu_r_id,
    output ext_biu_r_data,
    output ext_biu_r_last,
    output ext_biu_r_resp
  );

endinterface

// File: rtl/c7bbiu_rd_track.sv
// One-outstanding read tracker for a single requester.
// Matches RID, steers beats to the owner, drains cancelled reads.
module c7bbiu_rd_track
  import c7bbiu_pkg::*;
#(
  parameter logic [3:0] ID = 4'd0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        grant,
  input  logic        ar_hs,
  input  logic        cancel,
  input  logic        r_valid,
  input  logic [3:0]  r_id,
  input  logic [31:0] r_data,
  input  logic        r_last,
  input  logic [1:0]  r_resp,
  output logic        idle,
  output logic        drop,
  output logic        data_valid,
  output logic [31:0] data,
  output logic        data_last,
  output logic        rd_err
);

  trk_state_e state;
  trk_state_e state_nxt;
  logic       hit;
  logic       hit_last;

  assign hit      = r_valid & (r_id == ID);
  assign hit_last = hit & r_last;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= TRK_IDLE;
    else         state <= state_nxt;
  end

  // cancel wins over a same-cycle AR handshake: the read is drained
  always_comb begin
    state_nxt = state;
    unique case (state)
      TRK_IDLE: if (grant) state_nxt = TRK_ADDR;
      TRK_ADDR: begin
        if (cancel)     state_nxt = TRK_DROP;
        else if (ar_hs) state_nxt = TRK_DATA;
      end
      TRK_DATA: begin
        if (hit_last)    state_nxt = TRK_IDLE;
        else if (cancel) state_nxt = TRK_DROP;
      end
      TRK_DROP: if (hit_last) state_nxt = TRK_IDLE;
    endcase
  end

  assign idle       = (state == TRK_IDLE);
  assign drop       = (state == TRK_DROP);
  assign data_valid = hit & (state == TRK_DATA) & ~cancel;
  assign data       = r_data;
  assign data_last  = r_last;
  assign rd_err     = (r_resp != AXI_RESP_OKAY);

endmodule

// File: rtl/c7bbiu_rd_sched.sv
// Shares one AXI read channel between IFU fetch and LSU load.
// Round-robin AR grant, registered AR, RID-based R steering.
module c7bbiu_rd_sched
  import c7bbiu_pkg::*;
#(
  parameter logic [3:0] IFU_ARID = 4'd0,
  parameter logic [3:0] LSU_ARID = 4'd1,
  parameter logic [7:0] AR_LEN   = 8'd0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ifu_biu_rd_req,
  input  logic [31:0] ifu_biu_rd_addr,
  input  logic        ifu_biu_cancel,
  output logic        biu_ifu_rd_ack,
  output logic        biu_ifu_data_valid,
  output logic [31:0] biu_ifu_data,
  output logic        biu_ifu_data_last,
  output logic        biu_ifu_rd_err,
  input  logic        lsu_biu_rd_req,
  input  logic [31:0] lsu_biu_rd_addr,
  output logic        biu_lsu_rd_ack,
  output logic        biu_lsu_data_valid,
  output logic [31:0] biu_lsu_data,
  output logic        biu_lsu_data_last,
  output logic        biu_lsu_rd_err,
  c7bbiu_rd_sched_if.master axi
);

  logic        ar_valid;
  logic [3:0]  ar_id;
  logic [31:0] ar_addr;
  logic        r_ready;
  logic        prio_lsu;
  logic        ar_hs;
  logic        ar_free;
  logic        own_lsu;
  logic        ifu_idle, ifu_drop;
  logic        lsu_idle, lsu_drop;
  logic        ifu_elig, lsu_elig;
  logic        gnt_ifu, gnt_lsu;

  assign ar_hs   = ar_valid & axi.ext_biu_ar_ready;
  assign ar_free = ~ar_valid | ar_hs;
  assign own_lsu = (ar_id == LSU_ARID);

  assign ifu_elig = ifu_biu_rd_req & ifu_idle & ~ifu_biu_cancel;
  assign lsu_elig = lsu_biu_rd_req & lsu_idle;

  assign gnt_ifu = ar_free & ifu_elig & (~lsu_elig | ~prio_lsu);
  assign gnt_lsu = ar_free & lsu_elig & ~gnt_ifu;

  // prio_lsu names who wins the next tie; it flips to the loser on every grant
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ar_valid <= 1'b0;
      ar_id    <= 4'd0;
      ar_addr  <= 32'd0;
      prio_lsu <= 1'b0;
      r_ready  <= 1'b0;
    end else begin
      r_ready <= 1'b1;
      if (gnt_ifu) begin
        ar_valid <= 1'b1;
        ar_id    <= IFU_ARID;
        ar_addr  <= ifu_biu_rd_addr;
        prio_lsu <= 1'b1;
      end else if (gnt_lsu) begin
        ar_valid <= 1'b1;
        ar_id    <= LSU_ARID;
        ar_addr  <= lsu_biu_rd_addr;
        prio_lsu <= 1'b0;
      end else if (ar_hs) begin
        ar_valid <= 1'b0;
      end
    end
  end

  assign biu_ifu_rd_ack = ar_hs & ~own_lsu & ~ifu_biu_cancel & ~ifu_drop;
  assign biu_lsu_rd_ack = ar_hs & own_lsu;

  c7bbiu_rd_track #(.ID(IFU_ARID)) u_ifu_trk (
    .clk        (clk),
    .resetn     (resetn),
    .grant      (gnt_ifu),
    .ar_hs      (ar_hs & ~own_lsu),
    .cancel     (ifu_biu_cancel),
    .r_valid    (axi.ext_biu_r_valid),
    .r_id       (axi.ext_biu_r_id),
    .r_data     (axi.ext_biu_r_data),
    .r_last     (axi.ext_biu_r_last),
    .r_resp     (axi.ext_biu_r_resp),
    .idle       (ifu_idle),
    .drop       (ifu_drop),
    .data_valid (biu_ifu_data_valid),
    .data       (biu_ifu_data),
    .data_last  (biu_ifu_data_last),
    .rd_err     (biu_ifu_rd_err)
  );

  c7bbiu_rd_track #(.ID(LSU_ARID)) u_lsu_trk (
    .clk        (clk),
    .resetn     (resetn),
    .grant      (gnt_lsu),
    .ar_hs      (ar_hs & own_lsu),
    .cancel     (1'b0),
    .r_valid    (axi.ext_biu_r_valid),
    .r_id       (axi.ext_biu_r_id),
    .r_data     (axi.ext_biu_r_data),
    .r_last     (axi.ext_biu_r_last),
    .r_resp     (axi.ext_biu_r_resp),
    .idle       (lsu_idle),
    .drop       (lsu_drop),
    .data_valid (biu_lsu_data_valid),
    .data       (biu_lsu_data),
    .data_last  (biu_lsu_data_last),
    .rd_err     (biu_lsu_rd_err)
  );

  assign axi.biu_ext_ar_valid = ar_valid;
  assign axi.biu_ext_ar_id    = ar_id;
  assign axi.biu_ext_ar_addr  = ar_addr;
  assign axi.biu_ext_ar_len   = AR_LEN;
  assign axi.biu_ext_ar_size  = AXI_SIZE_4B;
  assign axi.biu_ext_ar_burst = AXI_BURST_INCR;
  assign axi.biu_ext_ar_lock  = 1'b0;
  assign axi.biu_ext_ar_cache = 4'd0;
  assign axi.biu_ext_ar_prot  = 3'd0;
  assign axi.biu_ext_r_ready  = r_ready;

  logic unused_ok;
  assign unused_ok = lsu_drop;

endmodule

// File: tb/tb_c7bbiu_rd_sched.sv
// Directed self-checking bench for c7bbiu_rd_sched.
// Inputs change 2ns after posedge; outputs sampled 1ns later.
module tb_c7bbiu_rd_sched;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ifu_req, ifu_cancel;
  logic [31:0] ifu_addr;
  logic        ifu_ack, ifu_dv, ifu_last, ifu_err;
  logic [31:0] ifu_data;
  logic        lsu_req;
  logic [31:0] lsu_addr;
  logic        lsu_ack, lsu_dv, lsu_last, lsu_err;
  logic [31:0] lsu_data;
  int          checks = 0;
  int          failures = 0;

  c7bbiu_rd_sched_if axi ();

  c7bbiu_rd_sched #(
    .IFU_ARID (4'd0),
    .LSU_ARID (4'd1),
    .AR_LEN   (8'd3)
  ) dut (
    .clk                (clk),
    .resetn             (resetn),
    .ifu_biu_rd_req     (ifu_req),
    .ifu_biu_rd_addr    (ifu_addr),
    .ifu_biu_cancel     (ifu_cancel),
    .biu_ifu_rd_ack     (ifu_ack),
    .biu_ifu_data_valid (ifu_dv),
    .biu_ifu_data       (ifu_data),
    .biu_ifu_data_last  (ifu_last),
    .biu_ifu_rd_err     (ifu_err),
    .lsu_biu_rd_req     (lsu_req),
    .lsu_biu_rd_addr    (lsu_addr),
    .biu_lsu_rd_ack     (lsu_ack),
    .biu_lsu_data_valid (lsu_dv),
    .biu_lsu_data       (lsu_data),
    .biu_lsu_data_last  (lsu_last),
    .biu_lsu_rd_err     (lsu_err),
    .axi                (axi.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic beat(input logic [3:0] id, input logic [31:0] d,
                      input logic last, input logic [1:0] resp);
    axi.ext_biu_r_valid = 1'b1;
    axi.ext_biu_r_id    = id;
    axi.ext_biu_r_data  = d;
    axi.ext_biu_r_last  = last;
    axi.ext_biu_r_resp  = resp;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    ifu_req = 1'b0;
    lsu_req = 1'b0;
    ifu_cancel = 1'b0;
    axi.ext_biu_r_valid = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    ifu_req = 1'b0; ifu_cancel = 1'b0; ifu_addr = 32'd0;
    lsu_req = 1'b0; lsu_addr = 32'd0;
    axi.ext_biu_ar_ready = 1'b0;
    beat(4'd0, 32'd0, 1'b0, 2'b00);
    axi.ext_biu_r_valid = 1'b0;
    #1;
    chk("rst_arv", axi.biu_ext_ar_valid, 0);
    chk("rst_rrdy", axi.biu_ext_r_ready, 0);
    chk("rst_ack", {ifu_ack, lsu_ack}, 0);
    chk("rst_dv", {ifu_dv, lsu_dv}, 0);
    tick(); tick();
    resetn = 1'b1;
    tick(); #1;
    chk("rrdy", axi.biu_ext_r_ready, 1);

    // single IFU read
    ifu_req = 1'b1; ifu_addr = 32'h1000; axi.ext_biu_ar_ready = 1'b1; #1;
    chk("t1_arv_lat", axi.biu_ext_ar_valid, 0);
    tick(); ifu_req = 1'b0; #1;
    chk("t1_arv", axi.biu_ext_ar_valid, 1);
    chk("t1_id", axi.biu_ext_ar_id, 0);
    chk("t1_addr", axi.biu_ext_ar_addr, 32'h1000);
    chk("t1_len", axi.biu_ext_ar_len, 3);
    chk("t1_size", axi.biu_ext_ar_size, 3'b010);
    chk("t1_burst", axi.biu_ext_ar_burst, 2'b01);
    chk("t1_ack", ifu_ack, 1);
    tick(); #1;
    chk("t1_arv_off", axi.biu_ext_ar_valid, 0);
    chk("t1_ack_pulse", ifu_ack, 0);
    beat(4'd0, 32'hDEADBEEF, 1'b1, 2'b00); #1;
    chk("t1_dv", ifu_dv, 1);
    chk("t1_data", ifu_data, 32'hDEADBEEF);
    chk("t1_last", ifu_last, 1);
    chk("t1_err", ifu_err, 0);
    chk("t1_lsu_dv", lsu_dv, 0);
    tick(); beat(4'd0, 32'h1234, 1'b1, 2'b00); #1;
    chk("t1_idle", ifu_dv, 0);
    tick(); axi.ext_biu_r_valid = 1'b0;

    // simultaneous pair after reset: IFU first
    do_reset();
    ifu_req = 1'b1; ifu_addr = 32'h2000;
    lsu_req = 1'b1; lsu_addr = 32'h3000; #1;
    tick(); ifu_req = 1'b0; #1;
    chk("p1_id0", axi.biu_ext_ar_id, 0);
    chk("p1_addr0", axi.biu_ext_ar_addr, 32'h2000);
    chk("p1_ack", {ifu_ack, lsu_ack}, 2'b10);
    tick(); lsu_req = 1'b0; #1;
    chk("p1_arv1", axi.biu_ext_ar_valid, 1);
    chk("p1_id1", axi.biu_ext_ar_id, 1);
    chk("p1_addr1", axi.biu_ext_ar_addr, 32'h3000);
    chk("p1_ack1", {ifu_ack, lsu_ack}, 2'b01);
    tick(); beat(4'd1, 32'h33333333, 1'b1, 2'b00); #1;
    chk("ooo_arv", axi.biu_ext_ar_valid, 0);
    chk("ooo_lsu_dv", {ifu_dv, lsu_dv}, 2'b01);
    chk("ooo_lsu_data", lsu_data, 32'h33333333);
    tick(); beat(4'd5, 32'h55, 1'b1, 2'b00); #1;
    chk("ooo_id5", {ifu_dv, lsu_dv}, 2'b00);
    tick(); beat(4'd0, 32'h22222222, 1'b1, 2'b00); #1;
    chk("ooo_ifu_dv", {ifu_dv, lsu_dv}, 2'b10);
    chk("ooo_ifu_data", ifu_data, 32'h22222222);
    tick(); axi.ext_biu_r_valid = 1'b0;

    // IFU cancel while AR stalled
    axi.ext_biu_ar_ready = 1'b0; ifu_req = 1'b1; ifu_addr = 32'h4000; #1;
    tick(); #1;
    chk("cx_arv_a", axi.biu_ext_ar_valid, 1);
    chk("cx_addr_a", axi.biu_ext_ar_addr, 32'h4000);
    tick(); ifu_cancel = 1'b1; ifu_req = 1'b0; #1;
    chk("cx_arv_b", axi.biu_ext_ar_valid, 1);
    chk("cx_ack_b", ifu_ack, 0);
    tick(); ifu_cancel = 1'b0; #1;
    chk("cx_arv_c", axi.biu_ext_ar_valid, 1);
    chk("cx_addr_c", axi.biu_ext_ar_addr, 32'h4000);
    tick(); axi.ext_biu_ar_ready = 1'b1; #1;
    chk("cx_id_hs", axi.biu_ext_ar_id, 0);
    chk("cx_ack_hs", ifu_ack, 0);
    tick(); beat(4'd0, 32'h44444444, 1'b1, 2'b00); #1;
    chk("cx_arv_off", axi.biu_ext_ar_valid, 0);
    chk("cx_rrdy", axi.biu_ext_r_ready, 1);
    chk("cx_dv", ifu_dv, 0);
    tick(); axi.ext_biu_r_valid = 1'b0;

    // second pair: last grant was IFU, so LSU first
    ifu_req = 1'b1; ifu_addr = 32'h5000;
    lsu_req = 1'b1; lsu_addr = 32'h6000; #1;
    tick(); lsu_req = 1'b0; #1;
    chk("p2_id", axi.biu_ext_ar_id, 1);
    chk("p2_addr", axi.biu_ext_ar_addr, 32'h6000);
    chk("p2_ack", {ifu_ack, lsu_ack}, 2'b01);
    tick(); ifu_req = 1'b0; #1;
    chk("p2_id2", axi.biu_ext_ar_id, 0);
    chk("p2_addr2", axi.biu_ext_ar_addr, 32'h5000);
    chk("p2_ack2", {ifu_ack, lsu_ack}, 2'b10);
    tick(); beat(4'd0, 32'h55555555, 1'b1, 2'b00); #1;
    chk("p2_ifu_dv", {ifu_dv, lsu_dv}, 2'b10);
    tick(); beat(4'd1, 32'h66666666, 1'b1, 2'b00); #1;
    chk("p2_lsu_dv", {ifu_dv, lsu_dv}, 2'b01);
    tick(); axi.ext_biu_r_valid = 1'b0;

    // LSU 4-beat burst, error on beat 2
    lsu_req = 1'b1; lsu_addr = 32'h7000; #1;
    tick(); lsu_req = 1'b0; #1;
    chk("bu_ack", lsu_ack, 1);
    chk("bu_addr", axi.biu_ext_ar_addr, 32'h7000);
    tick();
    for (int i = 0; i < 4; i++) begin
      beat(4'd1, 32'hA0 + i, (i == 3), (i == 1) ? 2'b10 : 2'b00); #1;
      chk("bu_dv", lsu_dv, 1);
      chk("bu_data", lsu_data, 32'hA0 + i);
      chk("bu_last", lsu_last, (i == 3));
      chk("bu_err", lsu_err, (i == 1));
      tick();
    end
    beat(4'd1, 32'hBB, 1'b1, 2'b00); #1;
    chk("bu_idle", lsu_dv, 0);
    tick(); axi.ext_biu_r_valid = 1'b0;

    // reset with IFU in DATA
    ifu_req = 1'b1; ifu_addr = 32'h8000; #1;
    tick(); ifu_req = 1'b0;
    tick();
    beat(4'd0, 32'h88888888, 1'b1, 2'b00);
    resetn = 1'b0; #1;
    chk("mr_addr", axi.biu_ext_ar_addr, 0);
    chk("mr_id", axi.biu_ext_ar_id, 0);
    chk("mr_rrdy", axi.biu_ext_r_ready, 0);
    chk("mr_dv", ifu_dv, 0);
    axi.ext_biu_r_valid = 1'b0;
    tick(); resetn = 1'b1;
    tick(); beat(4'd0, 32'h77777777, 1'b1, 2'b00); #1;
    chk("mr_stale", ifu_dv, 0);
    tick(); axi.ext_biu_r_valid = 1'b0;
    ifu_req = 1'b1; ifu_addr = 32'h9000; #1;
    chk("mr_arv0", axi.biu_ext_ar_valid, 0);
    tick(); ifu_req = 1'b0; #1;
    chk("mr_arv", axi.biu_ext_ar_valid, 1);
    chk("mr_addr2", axi.biu_ext_ar_addr, 32'h9000);
    chk("mr_ack", ifu_ack, 1);
    tick(); beat(4'd0, 32'h99999999, 1'b1, 2'b00); #1;
    chk("mr_dv2", ifu_dv, 1);
    chk("mr_data2", ifu_data, 32'h99999999);
    tick(); axi.ext_biu_r_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
